// File: rtl/udma_mram_sched_pkg.sv
// Shared types and header layout for the uDMA -> MRAM FIFO burst scheduler.
// Header word: mark bit at the MSB, channel id just above the length field,
// burst length in the low bits, every other bit zero. The constants and
// build_hdr() describe the default geometry (32-bit word, 16-bit length,
// 4 channels); other geometries are assembled generically in the top.
package udma_mram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam int HDR_DW       = 32;
  localparam int HDR_LW       = 16;
  localparam int HDR_CW       = 2;
  localparam int HDR_MARK_BIT = HDR_DW - 1;
  localparam int HDR_CH_LSB   = HDR_LW;
  localparam int HDR_LEN_LSB  = 0;

  function automatic logic [HDR_DW-1:0] build_hdr(input logic [HDR_CW-1:0] ch,
                                                  input logic [HDR_LW-1:0] len);
    logic [HDR_DW-1:0] h;
    h                            = '0;
    h[HDR_MARK_BIT]              = 1'b1;
    h[HDR_CH_LSB +: HDR_CW]      = ch;
    h[HDR_LEN_LSB +: HDR_LW]     = len;
    return h;
  endfunction

endpackage

// File: rtl/udma_mram_rr_arb.sv
// Combinational round-robin pick. Searches req starting one past rr_ptr
// (wrapping at N_CH), so the last winner has the lowest priority.
//   req     : request vector
//   rr_ptr  : index of the previous winner
//   gnt     : one-hot winner (0 when no request)
//   idx     : winner index (0 when no request)
//   any_req : at least one request set
module udma_mram_rr_arb #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] rr_ptr,
  output logic [N_CH-1:0]         gnt,
  output logic [$clog2(N_CH)-1:0] idx,
  output logic                    any_req
);

  localparam int CW = $clog2(N_CH);

  int   c;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 1; i <= N_CH; i++) begin
      c = (int'(rr_ptr) + i) % N_CH;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = CW'(c);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/udma_mram_burst_sched.sv
// Round-robin burst scheduler in front of the MRAM dual-clock FIFO write side.
// A granted channel owns the FIFO for one header word plus exactly len data
// words; the scheduler then drops back to IDLE for at least one cycle.
//   clk_i, rst_i             : source clock, synchronous active-high reset
//   ch_req_i / ch_len_i      : per-channel request and length, sampled in IDLE
//   ch_gnt_o                 : one-hot grant for the whole burst
//   ch_data_i/valid_i/ready_o: per-channel data stream
//   fifo_data_o/valid_o/ready_i : FIFO source port
//   busy_o, cur_ch_o, done_o : status; done_o pulses in the first IDLE cycle
module udma_mram_burst_sched
  import udma_mram_sched_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_CH-1:0]              ch_req_i,
  input  logic [N_CH*LEN_WIDTH-1:0]    ch_len_i,
  output logic [N_CH-1:0]              ch_gnt_o,
  input  logic [N_CH*DATA_WIDTH-1:0]   ch_data_i,
  input  logic [N_CH-1:0]              ch_valid_i,
  output logic [N_CH-1:0]              ch_ready_o,
  output logic [DATA_WIDTH-1:0]        fifo_data_o,
  output logic                         fifo_valid_o,
  input  logic                         fifo_ready_i,
  output logic                         busy_o,
  output logic [$clog2(N_CH)-1:0]      cur_ch_o,
  output logic                         done_o
);

  localparam int CH_W = $clog2(N_CH);

  state_e                state_q, state_d;
  logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]       gnt_q, gnt_d;
  logic                  done_q, done_d;

  logic [N_CH-1:0]       arb_gnt;
  logic [CH_W-1:0]       arb_idx;
  logic                  arb_any;
  logic [DATA_WIDTH-1:0] hdr_w;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  cur_valid;

  udma_mram_rr_arb #(.N_CH(N_CH)) u_arb (
    .req     (ch_req_i),
    .rr_ptr  (rr_ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  generate
    if (DATA_WIDTH == HDR_DW && LEN_WIDTH == HDR_LW && CH_W == HDR_CW) begin : g_hdr_pkg
      assign hdr_w = build_hdr(cur_ch_q, len_q);
    end else begin : g_hdr_gen
      always_comb begin
        hdr_w                    = '0;
        hdr_w[DATA_WIDTH-1]      = 1'b1;
        hdr_w[LEN_WIDTH +: CH_W] = cur_ch_q;
        hdr_w[LEN_WIDTH-1:0]     = len_q;
      end
    end
  endgenerate

  assign cur_data  = ch_data_i[cur_ch_q*DATA_WIDTH +: DATA_WIDTH];
  assign cur_valid = ch_valid_i[cur_ch_q];

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    rr_ptr_d = rr_ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          cur_ch_d = arb_idx;
          len_d    = ch_len_i[arb_idx*LEN_WIDTH +: LEN_WIDTH];
          rr_ptr_d = arb_idx;
          gnt_d    = arb_gnt;
          cnt_d    = '0;
          state_d  = HDR;
        end
      end
      HDR: begin
        if (fifo_ready_i) begin
          if (len_q != '0) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      DATA: begin
        if (cur_valid && fifo_ready_i) begin
          // len_q >= 1 here, so len_q-1 never underflows and cnt never wraps
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cur_ch_q <= '0;
      rr_ptr_q <= CH_W'(N_CH - 1);
      len_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      rr_ptr_q <= rr_ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  // Data phase is a pure mux: valid comes from the channel, never from
  // fifo_ready_i, so there is no ready->valid combinational path.
  always_comb begin
    fifo_valid_o = 1'b0;
    fifo_data_o  = '0;
    ch_ready_o   = '0;
    case (state_q)
      HDR: begin
        fifo_valid_o = 1'b1;
        fifo_data_o  = hdr_w;
      end
      DATA: begin
        fifo_valid_o         = cur_valid;
        fifo_data_o          = cur_data;
        ch_ready_o[cur_ch_q] = fifo_ready_i;
      end
      default: ;
    endcase
  end

  assign ch_gnt_o = gnt_q;
  assign busy_o   = (state_q != IDLE);
  assign cur_ch_o = cur_ch_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_udma_mram_burst_sched.sv
module tb_udma_mram_burst_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_req;
  logic [N*LW-1:0] ch_len;
  logic [N-1:0]    gnt;
  logic [N*DW-1:0] ch_data;
  logic [N-1:0]    ch_valid;
  logic [N-1:0]    ch_ready;
  logic [DW-1:0]   fifo_data;
  logic            fifo_valid;
  logic            fifo_ready;
  logic            busy;
  logic [1:0]      cur_ch;
  logic            done;

  always #5 clk = ~clk;

  udma_mram_burst_sched #(.N_CH(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_i(rst), .ch_req_i(ch_req), .ch_len_i(ch_len),
    .ch_gnt_o(gnt), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
    .ch_ready_o(ch_ready), .fifo_data_o(fifo_data), .fifo_valid_o(fifo_valid),
    .fifo_ready_i(fifo_ready), .busy_o(busy), .cur_ch_o(cur_ch), .done_o(done)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] lens[N];
  logic [N-1:0] vld_en;
  logic [31:0] srcq[N][$];
  logic [31:0] flog[$];
  logic [31:0] expq[$];
  int          done_cnt;

  function automatic logic [31:0] hdr(int ch, int len);
    return 32'h8000_0000 | (32'(ch) << 16) | 32'(len);
  endfunction

  function automatic logic [31:0] mkword(int k, int n);
    return 32'h0A00_0000 | (32'(k) << 20) | 32'(n);
  endfunction

  task automatic fill(int k, int n);
    for (int i = 0; i < n; i++) srcq[k].push_back(mkword(k, i));
  endtask

  // Reference: with a constant request mask the burst order is fixed by the
  // round-robin rule, and each burst is a header followed by len words that
  // channel produces in order.
  function automatic void model_stream(logic [N-1:0] mask, int nb);
    int ptr;
    int cnt[N];
    int c;
    ptr = N - 1;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    expq.delete();
    for (int b = 0; b < nb; b++) begin
      c = -1;
      for (int i = 1; i <= N; i++)
        if (c < 0 && mask[(ptr + i) % N]) c = (ptr + i) % N;
      expq.push_back(hdr(c, int'(lens[c])));
      for (int j = 0; j < int'(lens[c]); j++) begin
        expq.push_back(mkword(c, cnt[c]));
        cnt[c]++;
      end
      ptr = c;
    end
  endfunction

  task automatic settle();
    for (int k = 0; k < N; k++) begin
      ch_len[k*LW +: LW]  = lens[k];
      ch_valid[k]         = vld_en[k] && (srcq[k].size() > 0);
      ch_data[k*DW +: DW] = (srcq[k].size() > 0) ? srcq[k][0] : 32'h0;
    end
    #1;
  endtask

  task automatic edge_step();
    logic [N-1:0] pop;
    pop = ch_ready & ch_valid;
    if (fifo_valid && fifo_ready) flog.push_back(fifo_data);
    if (done) done_cnt++;
    @(posedge clk);
    for (int k = 0; k < N; k++) if (pop[k] === 1'b1) srcq[k].delete(0);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_req = '0; vld_en = '1; fifo_ready = 1'b1;
    for (int k = 0; k < N; k++) begin lens[k] = '0; srcq[k].delete(); end
    settle(); edge_step(); edge_step();
    flog.delete(); done_cnt = 0;
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({gnt, ch_ready, fifo_valid, busy, done, cur_ch} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt=%b rdy=%b v=%b busy=%b done=%b cur=%0d want all 0",
               gnt, ch_ready, fifo_valid, busy, done, cur_ch);
    end
    n_chk++;
    if (fifo_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", fifo_data);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp[4];
    do_reset();
    srcq[0].push_back(32'h11); srcq[0].push_back(32'h22); srcq[0].push_back(32'h33);
    lens[0] = 16'd3; ch_req = 4'b0001;
    settle(); edge_step();
    ch_req = '0;
    exp[0] = 32'h8000_0003; exp[1] = 32'h11; exp[2] = 32'h22; exp[3] = 32'h33;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_chk++;
      if (fifo_valid !== 1'b1 || fifo_data !== exp[i] || gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL single_word%0d: v=%b data=%h gnt=%b want v=1 data=%h gnt=0001",
                 i, fifo_valid, fifo_data, gnt, exp[i]);
      end
      edge_step();
    end
    settle();
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || gnt !== 4'b0) begin
      n_fail++; $display("FAIL single_done: done=%b busy=%b gnt=%b want 1 0 0000", done, busy, gnt);
    end
    edge_step(); settle();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL single_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < N; k++) begin lens[k] = 16'd1; fill(k, 4); end
    ch_req = 4'hF;
    // 5 bursts of header+1 word with a one-cycle gap occupy exactly 15 cycles
    for (int i = 0; i < 15; i++) begin settle(); edge_step(); end
    ch_req = '0;
    model_stream(4'hF, 5);
    n_chk++;
    if (flog.size() != expq.size()) begin
      n_fail++; $display("FAIL rr_count: got %0d words want %0d", flog.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        n_chk++;
        if (flog[i] !== expq[i]) begin
          n_fail++; $display("FAIL rr_word%0d: got %h want %h", i, flog[i], expq[i]);
        end
      end
    end
    settle(); edge_step();
  endtask

  task automatic test_hold();
    do_reset();
    lens[2] = 16'd2; fill(2, 2); ch_req = 4'b0100; fifo_ready = 1'b0;
    settle(); edge_step();
    ch_req = '0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_chk++;
      if (fifo_valid !== 1'b1 || fifo_data !== 32'h8002_0002 || ch_ready !== 4'b0) begin
        n_fail++;
        $display("FAIL hold_cyc%0d: v=%b data=%h rdy=%b want v=1 data=80020002 rdy=0000",
                 i, fifo_valid, fifo_data, ch_ready);
      end
      edge_step();
    end
    fifo_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin settle(); edge_step(); end
    settle();
    n_chk++;
    if (flog.size() != 3 || flog[0] !== 32'h8002_0002 || flog[1] !== mkword(2, 0) ||
        flog[2] !== mkword(2, 1) || done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_stream: %0d words, done=%b want hdr + 2 data then done", flog.size(), done);
    end
    edge_step();
  endtask

  task automatic test_zero_len();
    logic rdy_seen;
    rdy_seen = 1'b0;
    do_reset();
    lens[1] = 16'd0; fill(1, 2); ch_req = 4'b0010;
    settle(); edge_step();
    ch_req = '0;
    settle();
    rdy_seen |= ch_ready[1];
    n_chk++;
    if (fifo_valid !== 1'b1 || fifo_data !== 32'h8001_0000) begin
      n_fail++; $display("FAIL zlen_hdr: v=%b data=%h want 1 80010000", fifo_valid, fifo_data);
    end
    edge_step(); settle();
    rdy_seen |= ch_ready[1];
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zlen_done: done=%b busy=%b want 1 0", done, busy);
    end
    edge_step(); settle();
    n_chk++;
    if (rdy_seen !== 1'b0 || srcq[1].size() != 2) begin
      n_fail++; $display("FAIL zlen_noready: seen=%b left=%0d want 0 2", rdy_seen, srcq[1].size());
    end
  endtask

  task automatic test_toggle_valid();
    int hs;
    int i;
    hs = 0;
    do_reset();
    lens[0] = 16'd4; fill(0, 8); ch_req = 4'b0001;
    settle(); edge_step();
    settle(); edge_step();
    ch_req = '0;
    for (i = 0; i < 40; i++) begin
      vld_en[0] = ~i[0];
      settle();
      if (ch_valid[0] && ch_ready[0]) hs++;
      edge_step();
      if (!busy) break;
    end
    vld_en = '1;
    settle(); edge_step();
    n_chk++;
    if (i == 40) begin
      n_fail++; $display("FAIL toggle_timeout: burst still busy after 40 cycles");
    end
    n_chk++;
    if (hs != 4 || srcq[0].size() != 4 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL toggle_count: hs=%0d left=%0d done=%0d want 4 4 1", hs, srcq[0].size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lens[0] = 16'd5; fill(0, 5); ch_req = 4'b0001;
    settle(); edge_step();
    ch_req = '0;
    for (int i = 0; i < 3; i++) begin settle(); edge_step(); end
    rst = 1'b1;
    settle(); edge_step();
    rst = 1'b0;
    settle();
    n_chk++;
    if (busy !== 1'b0 || gnt !== 4'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: busy=%b gnt=%b done=%b want 0 0 0", busy, gnt, done);
    end
    lens[1] = 16'd1; fill(1, 1); ch_req = 4'b0011;
    settle(); edge_step();
    ch_req = '0;
    settle();
    n_chk++;
    if (cur_ch !== 2'd0 || gnt !== 4'b0001 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_rr: cur=%0d gnt=%b busy=%b want 0 0001 1", cur_ch, gnt, busy);
    end
    for (int i = 0; i < 8; i++) begin settle(); edge_step(); end
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int nb;
    int cyc;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      mask = N'($urandom_range(1, 15));
      nb = 6;
      for (int k = 0; k < N; k++) begin lens[k] = 16'($urandom_range(0, 4)); fill(k, 30); end
      model_stream(mask, nb);
      ch_req = mask;
      cyc = 0;
      while (done_cnt < nb && cyc < 400) begin
        fifo_ready = ($urandom % 4) != 0;
        vld_en = N'($urandom);
        settle();
        n_chk++;
        if ((ch_ready & ~gnt) !== '0 || (!busy && fifo_valid)) begin
          n_fail++;
          $display("FAIL rand_ctrl: rdy=%b gnt=%b busy=%b v=%b", ch_ready, gnt, busy, fifo_valid);
        end
        if (done && done_cnt + 1 == nb) begin ch_req = '0; settle(); end
        edge_step();
        cyc++;
      end
      n_chk++;
      if (cyc >= 400) begin
        n_fail++; $display("FAIL rand_timeout: %0d of %0d bursts done", done_cnt, nb);
      end
      n_chk++;
      if (flog.size() != expq.size()) begin
        n_fail++; $display("FAIL rand_count: got %0d words want %0d", flog.size(), expq.size());
      end else begin
        for (int i = 0; i < expq.size(); i++) begin
          n_chk++;
          if (flog[i] !== expq[i]) begin
            n_fail++; $display("FAIL rand_word%0d: got %h want %h", i, flog[i], expq[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_zero_len();
    test_toggle_valid();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
